bldc_cmd_sequencer: RTL and testbench
=====================================

# bldc_cmd_sequencer

Sequencer between the UART receiver and the four sensored-BLDC commutation controllers. It decodes received command bytes into per-motor 3-bit drive codes on `ui[11:0]`, one field per controller. It forces a dead-time coast whenever a motor reverses direction. A communication watchdog and an emergency-stop byte bring all four motors to a safe stop.

## Interface
Parameters:
- `DEAD_CYCLES`, default 1000: number of clk cycles a motor is held at code 000 before a reversed-direction code is applied. Valid range is ≥1.
- `TIMEOUT_CYCLES`, default 5_000_000: clk cycles without an accepted command before the watchdog trips.

Ports:
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `rx_data` input, 8 bits: received UART byte.
- `rx_valid` input, 1 bit: one-cycle strobe; `rx_data` is valid in the same cycle.
- `rx_err` input, 1 bit: framing/parity error, qualified by `rx_valid`.
- `ui` output, 12 bits: drive codes. Bits [2:0] go to motor 0, [5:3] to motor 1, [8:6] to motor 2, [11:9] to motor 3.
- `busy` output, 4 bits: bit m is high while motor m is in its dead-time coast.
- `cmd_ack` output, 1 bit: one-cycle pulse when a command is accepted.
- `cmd_err` output, 1 bit: one-cycle pulse when a byte is rejected.
- `wd_fault` output, 1 bit: sticky watchdog-trip flag.

## Operation
**Drive code.** Bit [2] is direction. Bits [1:0] are drive level. A code is "off" when [1:0]==00.

**Byte format.** [7:6] is the motor id, [5:3] is the code, and [2:0] is the marker 3'b101.
- Byte 8'h00 is ESTOP.
- Any other byte whose marker ≠ 101, or any byte received with `rx_err`=1, is rejected: `cmd_err` pulses and no state changes.

**ESTOP.** All four `ui` fields go to 000. All pending codes and coasts are cleared, `busy` goes to 0, and `cmd_ack` pulses. `wd_fault` is left unchanged. ESTOP reloads the watchdog.

**Per-motor FSM.** States are RUN and COAST. Each motor holds `cur` (the driven code) and `pend` (the target code).
- *RUN, reversal.* The new code is a reversal when `cur` is not off, the new code is not off, and their bit [2] values differ. Action: set `ui` field=000, `pend`=new, load the timer, and go to COAST.
- *RUN, otherwise.* `ui` field=new code; stay in RUN.
- *COAST, new command for this motor.* `pend` is overwritten. The timer is **not** restarted.
- *COAST, timer expiry.* `ui` field=`pend`; go to RUN.
- *COAST, off code received.* The off code is stored as `pend` and is applied at expiry. The field is already 000.

**Watchdog.** The counter reloads on every accepted command, including ESTOP. On reaching `TIMEOUT_CYCLES` with no accepted command, the block applies the ESTOP action and sets `wd_fault`=1.
- `wd_fault` clears on the next accepted non-ESTOP command.
- That command is then processed normally. From an all-off state it can never be a reversal.

**Simultaneous events.** A watchdog trip and `rx_valid` in the same cycle: the accepted command wins and the watchdog reloads. A rejected byte does not reload the watchdog.

## Timing
**Reset values.** `ui`=0, `busy`=0, `cmd_ack`=0, `cmd_err`=0, `wd_fault`=0. All FSMs are in RUN with `cur`=`pend`=000. The watchdog is loaded.
- Reset asserted mid-coast aborts the coast immediately (asynchronous).

**Non-reversal command.** `rx_valid` in cycle N gives the updated `ui` field and `cmd_ack`=1 in cycle N+1.

**Reversal command.** `rx_valid` in cycle N:
- From N+1: field=000 and `busy`=1.
- In cycle N+1+`DEAD_CYCLES`: field=`pend` and `busy`=0.
- The motor is therefore at 000 for exactly `DEAD_CYCLES` cycles.

**Rejection.** `cmd_err` pulses in cycle N+1.

**Watchdog trip.** If the last accepted command is in cycle N, the trip happens in cycle N+`TIMEOUT_CYCLES`. All fields are 000 and `wd_fault`=1 from the next cycle.

**Throughput.** One byte per cycle is accepted; there is no backpressure.

## Structure
**Shared package `bldc_pkg`:**
- Byte field positions.
- `MARKER`=3'b101 and `ESTOP_BYTE`=8'h00.
- Code field width of 3 and `N_MOTORS`=4.
- State enum {RUN, COAST}.
- Function `is_off(code)`.

**Sub-module `motor_cmd_seq`** contains one motor's FSM, `cur`, `pend`, and the dead-time counter. Inputs are `clk`, `rst_n`, `load`, `code`, and `kill`; outputs are `ui_field` and `busy`. It is instantiated 4 times.

**Top level** holds the byte decoder, the watchdog, and the ack/err pulse logic.

## Test plan
1. **Basic command.** After reset, send byte 8'b00_011_101 → cycle N+1: `ui[2:0]`=011 and `cmd_ack`=1; other fields stay 000.
2. **Reversal.** With motor 1 at 011, send 8'b01_111_101 → `ui[5:3]`=000 and `busy[1]`=1 for exactly `DEAD_CYCLES` (set to 8) cycles, then 111.
3. **Overwrite during coast.** During the coast of scenario 2, send 8'b01_110_101 → the coast end time is unchanged and 110 is applied at expiry.
4. **Rejection.** Send 8'b10_011_100 and, separately, a valid byte with `rx_err`=1 → each gives a `cmd_err` pulse; `ui` and the watchdog are unchanged.
5. **ESTOP mid-coast.** With all motors driving and motor 2 in coast, send 8'h00 → `ui`=0 and `busy`=0 in the next cycle; `wd_fault` stays 0.
6. **Watchdog.** Set `TIMEOUT_CYCLES`=20 and send no bytes → after 20 cycles `ui`=0 and `wd_fault`=1. Then send 8'b11_001_101 → `wd_fault`=0 and `ui[11:9]`=001.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC command sequencer: command byte layout,
// drive-code type, motor FSM states and the drive-code helper.
package bldc_pkg;

   localparam int CODE_W   = 3;
   localparam int N_MOTORS = 4;

   localparam int ID_MSB   = 7;
   localparam int ID_LSB   = 6;
   localparam int CODE_MSB = 5;
   localparam int CODE_LSB = 3;
   localparam int MARK_MSB = 2;
   localparam int MARK_LSB = 0;

   localparam logic [2:0] MARKER     = 3'b101;
   localparam logic [7:0] ESTOP_BYTE = 8'h00;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      COAST = 1'b1
   } motor_state_e;

   // A code is "off" when its drive level bits are zero; direction is ignored.
   function automatic logic is_off(input code_t code);
      return (code & 3'b011) == 3'b000;
   endfunction

endpackage

// File: rtl/bldc_cmd_sequencer_if.sv
// Received-byte bus from the UART receiver into the command sequencer.
interface bldc_cmd_sequencer_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;

   modport master (output rx_data, output rx_valid, output rx_err);
   modport slave  (input  rx_data, input  rx_valid, input  rx_err);

endinterface

// File: rtl/motor_cmd_seq.sv
// One motor's RUN/COAST sequencer: applies codes directly, or forces a
// dead-time coast at 000 before applying a direction-reversing code.
module motor_cmd_seq
   import bldc_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 1000
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  code_t code,
   input  logic  kill,
   output code_t ui_field,
   output logic  busy
);

   localparam int          DW        = $clog2(DEAD_CYCLES + 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

   motor_state_e  state_r;
   code_t         pend_r;
   logic [DW-1:0] timer_r;
   logic          reversal_s;
   code_t         expiry_code_s;

   // Reversal test against the driven code; a command landing on the expiry
   // cycle is the newest target, so it is the one applied.
   always_comb begin
      reversal_s    = !is_off(ui_field) && !is_off(code) &&
                      (ui_field[CODE_W-1] != code[CODE_W-1]);
      expiry_code_s = pend_r;
      if (load) begin
         expiry_code_s = code;
      end else begin
         expiry_code_s = pend_r;
      end
   end

   // Motor FSM, target code and dead-time counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= RUN;
         ui_field <= 3'b000;
         pend_r   <= 3'b000;
         timer_r  <= {DW{1'b0}};
         busy     <= 1'b0;
      end else if (kill) begin
         state_r  <= RUN;
         ui_field <= 3'b000;
         pend_r   <= 3'b000;
         timer_r  <= {DW{1'b0}};
         busy     <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (load) begin
                  pend_r <= code;
                  if (reversal_s) begin
                     ui_field <= 3'b000;
                     timer_r  <= DEAD_LOAD;
                     busy     <= 1'b1;
                     state_r  <= COAST;
                  end else begin
                     ui_field <= code;
                  end
               end
            end
            COAST: begin
               // New commands only retarget the coast; the end time is fixed.
               if (timer_r == {DW{1'b0}}) begin
                  ui_field <= expiry_code_s;
                  pend_r   <= expiry_code_s;
                  busy     <= 1'b0;
                  state_r  <= RUN;
               end else begin
                  timer_r <= timer_r - DW'(1);
                  if (load) begin
                     pend_r <= code;
                  end
               end
            end
            default: begin
               state_r  <= RUN;
               ui_field <= 3'b000;
               pend_r   <= 3'b000;
               timer_r  <= {DW{1'b0}};
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bldc_cmd_sequencer.sv
// Decodes UART command bytes into four motor drive codes, with ESTOP,
// a communication watchdog and ack/err pulses.
module bldc_cmd_sequencer
   import bldc_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bldc_cmd_sequencer_if.slave  rx,
   output logic [11:0]          ui,
   output logic [3:0]           busy,
   output logic                 cmd_ack,
   output logic                 cmd_err,
   output logic                 wd_fault
);

   localparam int            WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            valid_ok_s;
   logic            estop_s;
   logic            cmd_s;
   logic            reject_s;
   logic            accept_s;
   logic            trip_s;
   logic            kill_s;
   code_t           code_s;
   logic [1:0]      id_s;

   // Byte decode; an accepted command in the trip cycle suppresses the trip.
   always_comb begin
      valid_ok_s = rx.rx_valid && !rx.rx_err;
      estop_s    = valid_ok_s && (rx.rx_data == ESTOP_BYTE);
      cmd_s      = valid_ok_s && (rx.rx_data[MARK_MSB:MARK_LSB] == MARKER);
      reject_s   = rx.rx_valid && !estop_s && !cmd_s;
      accept_s   = estop_s || cmd_s;
      trip_s     = (wd_cnt_r == WD_MAX) && !accept_s;
      kill_s     = estop_s || trip_s;
      code_s     = rx.rx_data[CODE_MSB:CODE_LSB];
      id_s       = rx.rx_data[ID_MSB:ID_LSB];
   end

   // Watchdog: cycles since the last accepted byte, saturating once tripped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (accept_s) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (wd_cnt_r != WD_MAX) begin
         wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
         wd_cnt_r <= wd_cnt_r;
      end
   end

   // Ack/err pulses and the sticky watchdog flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ack  <= 1'b0;
         cmd_err  <= 1'b0;
         wd_fault <= 1'b0;
      end else begin
         cmd_ack <= accept_s;
         cmd_err <= reject_s;
         if (cmd_s) begin
            wd_fault <= 1'b0;
         end else if (trip_s) begin
            wd_fault <= 1'b1;
         end else begin
            wd_fault <= wd_fault;
         end
      end
   end

   for (genvar m = 0; m < N_MOTORS; m++) begin : g_motor
      logic load_s;
      assign load_s = cmd_s && (id_s == 2'(m));

      motor_cmd_seq #(
         .DEAD_CYCLES (DEAD_CYCLES)
      ) u_motor (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load_s),
         .code     (code_s),
         .kill     (kill_s),
         .ui_field (ui[CODE_W*m +: CODE_W]),
         .busy     (busy[m])
      );
   end

endmodule

// File: tb/tb_bldc_cmd_sequencer.sv
// Directed bench for bldc_cmd_sequencer with DEAD_CYCLES=8, TIMEOUT_CYCLES=20.
module tb_bldc_cmd_sequencer;

   localparam int unsigned DEAD = 8;
   localparam int unsigned TMO  = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] ui;
   logic [3:0]  busy;
   logic        cmd_ack;
   logic        cmd_err;
   logic        wd_fault;
   int          checks = 0;
   int          errors = 0;

   bldc_cmd_sequencer_if rx_if ();

   bldc_cmd_sequencer #(
      .DEAD_CYCLES    (DEAD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx_if),
      .ui       (ui),
      .busy     (busy),
      .cmd_ack  (cmd_ack),
      .cmd_err  (cmd_err),
      .wd_fault (wd_fault)
   );

   always #5 clk = ~clk;

   // Called at a falling edge; byte is presented for exactly one cycle and the
   // task returns at the next falling edge, i.e. in cycle N+1.
   task automatic send_byte(input logic [7:0] b, input logic err);
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      rx_if.rx_err   = err;
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      rx_if.rx_err   = 1'b0;
      rx_if.rx_data  = 8'h00;
   endtask

   task automatic apply_reset();
      rx_if.rx_data  = 8'h00;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_err   = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rx_if.rx_data  = 8'h00;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_err   = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ui !== 12'h000) begin errors++; $display("FAIL reset_ui got %h exp %h", ui, 12'h000); end
      checks++;
      if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %b exp %b", busy, 4'h0); end
      checks++;
      if ({cmd_ack, cmd_err, wd_fault} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b exp %b", {cmd_ack, cmd_err, wd_fault}, 3'b000);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      apply_reset();
      send_byte(8'h1D, 1'b0);
      checks++;
      if (ui !== 12'h003) begin errors++; $display("FAIL basic_ui got %h exp %h", ui, 12'h003); end
      checks++;
      if (cmd_ack !== 1'b1 || cmd_err !== 1'b0) begin
         errors++; $display("FAIL basic_ack got ack=%b err=%b exp ack=1 err=0", cmd_ack, cmd_err);
      end
      @(negedge clk);
      checks++;
      if (cmd_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse got %b exp 0", cmd_ack); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      send_byte(8'h1D, 1'b0);
      send_byte(8'h5D, 1'b0);
      checks++;
      if (ui !== 12'h01B || cmd_ack !== 1'b1) begin
         errors++; $display("FAIL b2b_second got ui=%h ack=%b exp ui=%h ack=1", ui, cmd_ack, 12'h01B);
      end
      // 011 -> 100 (off) and 100 -> 111 are not reversals
      send_byte(8'h25, 1'b0);
      checks++;
      if (ui !== 12'h01C || busy !== 4'h0) begin
         errors++; $display("FAIL b2b_to_off got ui=%h busy=%b exp ui=%h busy=0000", ui, busy, 12'h01C);
      end
      send_byte(8'h3D, 1'b0);
      checks++;
      if (ui !== 12'h01F || busy !== 4'h0) begin
         errors++; $display("FAIL b2b_from_off got ui=%h busy=%b exp ui=%h busy=0000", ui, busy, 12'h01F);
      end
   endtask

   task automatic test_reversal();
      int zero_cnt;
      int first;
      apply_reset();
      send_byte(8'h5D, 1'b0);
      checks++;
      if (ui !== 12'h018) begin errors++; $display("FAIL rev_setup got %h exp %h", ui, 12'h018); end
      send_byte(8'h7D, 1'b0);
      checks++;
      if (cmd_ack !== 1'b1) begin errors++; $display("FAIL rev_ack got %b exp 1", cmd_ack); end
      zero_cnt = 0;
      first = 0;
      for (int c = 1; c <= 12; c++) begin
         if (ui[5:3] == 3'b000 && busy[1] == 1'b1) zero_cnt++;
         if (first == 0 && ui[5:3] == 3'b111) first = c;
         @(negedge clk);
      end
      checks++;
      if (zero_cnt != 8) begin errors++; $display("FAIL rev_coast_len got %0d exp 8", zero_cnt); end
      checks++;
      if (first != 9) begin errors++; $display("FAIL rev_apply_cycle got %0d exp 9", first); end
      checks++;
      if (ui !== 12'h038 || busy !== 4'h0) begin
         errors++; $display("FAIL rev_final got ui=%h busy=%b exp ui=%h busy=0000", ui, busy, 12'h038);
      end
   endtask

   task automatic test_overwrite();
      int zero_cnt;
      int first;
      apply_reset();
      send_byte(8'h5D, 1'b0);
      send_byte(8'h7D, 1'b0);
      zero_cnt = 0;
      first = 0;
      for (int c = 1; c <= 12; c++) begin
         if (ui[5:3] == 3'b000 && busy[1] == 1'b1) zero_cnt++;
         if (first == 0 && ui[5:3] == 3'b110) first = c;
         if (c == 3) begin
            rx_if.rx_data  = 8'h75;
            rx_if.rx_valid = 1'b1;
         end
         @(negedge clk);
         rx_if.rx_valid = 1'b0;
         rx_if.rx_data  = 8'h00;
      end
      checks++;
      if (zero_cnt != 8) begin errors++; $display("FAIL ovw_coast_len got %0d exp 8", zero_cnt); end
      checks++;
      if (first != 9) begin errors++; $display("FAIL ovw_apply_cycle got %0d exp 9", first); end
      checks++;
      if (ui !== 12'h030) begin errors++; $display("FAIL ovw_final got %h exp %h", ui, 12'h030); end
   endtask

   task automatic test_reject();
      int c;
      apply_reset();
      send_byte(8'h1D, 1'b0);
      send_byte(8'h9C, 1'b0);
      checks++;
      if (cmd_err !== 1'b1 || cmd_ack !== 1'b0 || ui !== 12'h003) begin
         errors++; $display("FAIL rej_marker got err=%b ack=%b ui=%h exp err=1 ack=0 ui=%h", cmd_err, cmd_ack, ui, 12'h003);
      end
      send_byte(8'h9D, 1'b1);
      checks++;
      if (cmd_err !== 1'b1 || cmd_ack !== 1'b0 || ui !== 12'h003) begin
         errors++; $display("FAIL rej_rxerr got err=%b ack=%b ui=%h exp err=1 ack=0 ui=%h", cmd_err, cmd_ack, ui, 12'h003);
      end
      @(negedge clk);
      checks++;
      if (cmd_err !== 1'b0) begin errors++; $display("FAIL rej_pulse got %b exp 0", cmd_err); end
      // Rejected bytes must not reload: trip still N+20, visible at N+21
      c = 4;
      while (wd_fault !== 1'b1 && c < 40) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c != 21) begin errors++; $display("FAIL rej_wd_timing got %0d exp 21", c); end
      checks++;
      if (ui !== 12'h000) begin errors++; $display("FAIL rej_wd_ui got %h exp %h", ui, 12'h000); end
   endtask

   task automatic test_estop();
      apply_reset();
      send_byte(8'h1D, 1'b0);
      send_byte(8'h5D, 1'b0);
      send_byte(8'h9D, 1'b0);
      send_byte(8'hDD, 1'b0);
      checks++;
      if (ui !== 12'h6DB) begin errors++; $display("FAIL estop_setup got %h exp %h", ui, 12'h6DB); end
      send_byte(8'hBD, 1'b0);
      checks++;
      if (ui !== 12'h61B || busy !== 4'b0100) begin
         errors++; $display("FAIL estop_coast got ui=%h busy=%b exp ui=%h busy=0100", ui, busy, 12'h61B);
      end
      @(negedge clk);
      send_byte(8'h00, 1'b0);
      checks++;
      if (ui !== 12'h000 || busy !== 4'h0 || cmd_ack !== 1'b1 || wd_fault !== 1'b0) begin
         errors++; $display("FAIL estop_apply got ui=%h busy=%b ack=%b wd=%b exp 000 0000 1 0", ui, busy, cmd_ack, wd_fault);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (ui !== 12'h000 || busy !== 4'h0) begin
         errors++; $display("FAIL estop_cleared got ui=%h busy=%b exp 000 0000", ui, busy);
      end
   endtask

   task automatic test_watchdog();
      int c;
      apply_reset();
      repeat (19) @(negedge clk);
      checks++;
      if (wd_fault !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", wd_fault); end
      @(negedge clk);
      checks++;
      if (wd_fault !== 1'b1 || ui !== 12'h000) begin
         errors++; $display("FAIL wd_trip got wd=%b ui=%h exp wd=1 ui=000", wd_fault, ui);
      end
      send_byte(8'hCD, 1'b0);
      checks++;
      if (wd_fault !== 1'b0 || ui !== 12'h200 || cmd_ack !== 1'b1) begin
         errors++; $display("FAIL wd_recover got wd=%b ui=%h ack=%b exp wd=0 ui=200 ack=1", wd_fault, ui, cmd_ack);
      end
      // Command landing in the trip cycle (N+20) wins over the trip
      repeat (19) @(negedge clk);
      send_byte(8'h1D, 1'b0);
      checks++;
      if (wd_fault !== 1'b0 || ui !== 12'h203) begin
         errors++; $display("FAIL wd_cmd_wins got wd=%b ui=%h exp wd=0 ui=203", wd_fault, ui);
      end
      c = 1;
      while (wd_fault !== 1'b1 && c < 40) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c != 21 || ui !== 12'h000) begin
         errors++; $display("FAIL wd_retrip got cycle=%0d ui=%h exp cycle=21 ui=000", c, ui);
      end
   endtask

   task automatic test_reset_mid_coast();
      apply_reset();
      send_byte(8'h5D, 1'b0);
      send_byte(8'h7D, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ui !== 12'h000 || busy !== 4'h0) begin
         errors++; $display("FAIL rst_mid_coast got ui=%h busy=%b exp 000 0000", ui, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rx_if.rx_data  = 8'h00;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_err   = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reversal();
      test_overwrite();
      test_reject();
      test_estop();
      test_watchdog();
      test_reset_mid_coast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
